// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the up/down counter.
// Direction and mode encodings plus a load-value clamp.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Limits a requested value to the counter's top count.
  function automatic longint unsigned clamp(
    input longint unsigned v,
    input longint unsigned lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// counter_next_val: next count and limit-event flag for one enabled step.
// Ports: q/en/up_dn in; q_next, limit (en and q at the limit for direction) out.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 1,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q_next,
  output logic             limit
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam bit               SAT  = (SATURATE == MODE_SAT);

  logic at_max;
  logic at_min;

  assign at_max = (q == MAXV);
  assign at_min = (q == '0);

  // Limits are compared explicitly so a non-power-of-two modulus
  // never depends on natural WIDTH-bit rollover.
  always_comb begin
    q_next = q;
    limit  = 1'b0;
    if (en) begin
      unique case (up_dn)
        DIR_UP: begin
          if (at_max) begin
            limit  = 1'b1;
            q_next = SAT ? MAXV : '0;
          end else begin
            q_next = q + WIDTH'(1);
          end
        end
        DIR_DN: begin
          if (at_min) begin
            limit  = 1'b1;
            q_next = SAT ? '0 : MAXV;
          end else begin
            q_next = q - WIDTH'(1);
          end
        end
        default: q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter, modulus MAX_VAL+1, wrap or saturate.
// Ports: clk, reset_n, en, up_dn, load, load_val, clr in; Q, tc, wrap, ovf out.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 1,
  parameter int              SATURATE  = MODE_WRAP,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam longint unsigned TOP =
    (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] RST_Q =
    WIDTH'(RESET_VAL);

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  if (MAX_VAL > TOP) begin : g_bad_max
    $error("MAX_VAL does not fit in WIDTH bits");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("RESET_VAL exceeds MAX_VAL");
  end
  if (SATURATE != MODE_WRAP &&
      SATURATE != MODE_SAT) begin : g_bad_mode
    $error("SATURATE must be 0 or 1");
  end

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_q;
  logic             limit;

  counter_next_val #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .q      (Q),
    .en     (en),
    .up_dn  (up_dn),
    .q_next (q_next),
    .limit  (limit)
  );

  assign load_q = WIDTH'(clamp(64'(load_val), MAX_VAL));

  // The limit condition is exactly the terminal-count definition.
  assign tc = limit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Q    <= RST_Q;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      Q    <= RST_Q;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      Q    <= load_q;
      wrap <= 1'b0;
    end else begin
      Q    <= q_next;
      wrap <= limit;
      if (limit) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: vectors plus scoreboard for three configurations.
// a: MAX 9 wrap, b: MAX 9 saturate, c: MAX 15 wrap with RESET_VAL 3.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n, en, up_dn, load, clr;
  logic [3:0] load_val;

  logic [3:0] q_a, q_b, q_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       ovf_a, ovf_b, ovf_c;

  param_updown_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .clr(clr),
    .Q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
  );

  param_updown_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RESET_VAL(0)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .clr(clr),
    .Q(q_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
  );

  param_updown_counter #(
    .WIDTH(4), .MAX_VAL(15), .SATURATE(0), .RESET_VAL(3)
  ) u_full (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .clr(clr),
    .Q(q_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic       w;
    logic       o;
  } st_t;

  typedef struct packed {
    st_t a;
    st_t b;
    st_t c;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic [3:0] q;
    logic       w;
    logic       o;
    logic       tc;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];
  st_t  ma, mb, mc;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Reference behaviour of one counter for the inputs now applied.
  function automatic st_t step(input st_t s, input int maxv,
                               input bit sat, input int rv);
    st_t n;
    n = s;
    n.w = 1'b0;
    if (!reset_n || clr) begin
      n.q = 4'(rv);
      n.o = 1'b0;
    end else if (load) begin
      n.q = (int'(load_val) > maxv) ? 4'(maxv) : load_val;
    end else if (en && up_dn) begin
      if (int'(s.q) == maxv) begin
        n.w = 1'b1;
        n.o = 1'b1;
        n.q = sat ? 4'(maxv) : 4'd0;
      end else begin
        n.q = s.q + 4'd1;
      end
    end else if (en) begin
      if (s.q == 4'd0) begin
        n.w = 1'b1;
        n.o = 1'b1;
        n.q = sat ? 4'd0 : 4'(maxv);
      end else begin
        n.q = s.q - 4'd1;
      end
    end
    return n;
  endfunction

  function automatic logic tcm(input logic [3:0] q,
                               input int maxv);
    return en & (up_dn ? (int'(q) == maxv) : (q == 4'd0));
  endfunction

  task automatic chk_inst(input string tag,
                          input logic [3:0] q,
                          input logic w, input logic o,
                          input logic t,
                          input st_t e, input logic te);
    chk({tag, "_q"}, 32'(q), 32'(e.q));
    chk({tag, "_wrap"}, 32'(w), 32'(e.w));
    chk({tag, "_ovf"}, 32'(o), 32'(e.o));
    chk({tag, "_tc"}, 32'(t), 32'(te));
  endtask

  // Push expectations as stimulus goes in, pop after the edge.
  task automatic cycle();
    exp_t e;
    ma = step(ma, 9, 1'b0, 0);
    mb = step(mb, 9, 1'b1, 0);
    mc = step(mc, 15, 1'b0, 3);
    sbq.push_back('{ma, mb, mc});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk_inst("sb_a", q_a, wrap_a, ovf_a, tc_a, e.a, tcm(e.a.q, 9));
    chk_inst("sb_b", q_b, wrap_b, ovf_b, tc_b, e.b, tcm(e.b.q, 9));
    chk_inst("sb_c", q_c, wrap_c, ovf_c, tc_c, e.c, tcm(e.c.q, 15));
  endtask

  task automatic drive(input bit r, input bit c, input bit l,
                       input int lv, input bit e, input bit u);
    reset_n  = r;
    clr      = c;
    load     = l;
    load_val = 4'(lv);
    en       = e;
    up_dn    = u;
  endtask

  function automatic vec_t v(input bit r, input bit c, input bit l,
                             input int lv, input bit e, input bit u,
                             input int q, input bit w, input bit o,
                             input bit t);
    return '{r, c, l, 4'(lv), e, u, 4'(q), w, o, t};
  endfunction

  initial begin
    ma = '0;
    mb = '0;
    mc = '0;
    drive(0, 0, 0, 0, 0, 1);

    // reset with en high, then count up through the wrap
    vt.push_back(v(0,0,0,0,1,1, 0,0,0,0));
    vt.push_back(v(0,0,0,0,1,1, 0,0,0,0));
    for (int k = 1; k <= 8; k++)
      vt.push_back(v(1,0,0,0,1,1, k,0,0,0));
    vt.push_back(v(1,0,0,0,1,1, 9,0,0,1));
    vt.push_back(v(1,0,0,0,1,1, 0,1,1,0));
    vt.push_back(v(1,0,0,0,1,1, 1,0,1,0));
    vt.push_back(v(1,0,0,0,1,1, 2,0,1,0));
    // down wrap
    vt.push_back(v(1,0,1,2,0,0, 2,0,1,0));
    vt.push_back(v(1,0,0,0,1,0, 1,0,1,0));
    vt.push_back(v(1,0,0,0,1,0, 0,0,1,1));
    vt.push_back(v(1,0,0,0,1,0, 9,1,1,0));
    vt.push_back(v(1,0,0,0,1,0, 8,0,1,0));
    // priority: clr beats load beats en; load clamps
    vt.push_back(v(1,1,1,5,1,1, 0,0,0,0));
    vt.push_back(v(1,0,1,15,1,1, 9,0,0,1));
    vt.push_back(v(1,0,0,0,1,1, 0,1,1,0));
    // hold, then reset overriding load and en
    vt.push_back(v(1,0,1,6,0,1, 6,0,1,0));
    for (int k = 0; k < 5; k++)
      vt.push_back(v(1,0,0,0,0,1, 6,0,1,0));
    vt.push_back(v(0,0,1,7,1,1, 0,0,0,0));
    vt.push_back(v(1,0,0,0,1,1, 1,0,0,0));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].clr, vt[i].ld,
            int'(vt[i].lv), vt[i].en, vt[i].up);
      cycle();
      chk($sformatf("vec%0d_q", i), 32'(q_a), 32'(vt[i].q));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap_a), 32'(vt[i].w));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf_a), 32'(vt[i].o));
      chk($sformatf("vec%0d_tc", i), 32'(tc_a), 32'(vt[i].tc));
    end

    // saturate: blocked counts keep wrap high
    drive(1, 1, 0, 0, 0, 1);
    cycle();
    chk("sat_clr_q", 32'(q_b), 32'd0);
    chk("sat_clr_ovf", 32'(ovf_b), 32'd0);
    drive(1, 0, 1, 8, 0, 1);
    cycle();
    chk("sat_load_q", 32'(q_b), 32'd8);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 1, 1);
      cycle();
      chk($sformatf("sat_up%0d_q", k), 32'(q_b), 32'd9);
      chk($sformatf("sat_up%0d_wrap", k), 32'(wrap_b),
          32'(k != 0));
      chk($sformatf("sat_up%0d_ovf", k), 32'(ovf_b),
          32'(k != 0));
      chk($sformatf("sat_up%0d_tc", k), 32'(tc_b), 32'd1);
    end
    drive(1, 0, 0, 0, 1, 0);
    cycle();
    chk("sat_dn_q", 32'(q_b), 32'd8);
    chk("sat_dn_wrap", 32'(wrap_b), 32'd0);
    chk("sat_dn_ovf", 32'(ovf_b), 32'd1);

    // full-width modulus with nonzero reset value
    drive(0, 0, 0, 0, 1, 1);
    cycle();
    chk("full_rst_q", 32'(q_c), 32'd3);
    for (int k = 1; k <= 13; k++) begin
      drive(1, 0, 0, 0, 1, 1);
      cycle();
      chk($sformatf("full_up%0d_q", k), 32'(q_c),
          32'((3 + k) % 16));
      chk($sformatf("full_up%0d_wrap", k), 32'(wrap_c),
          32'(k == 13));
    end

    // random traffic against the reference model
    for (int k = 0; k < 1000; k++) begin
      drive($urandom_range(0, 49) != 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
